// File: rtl/pll_lock_supervisor.sv
// PLL reset-and-lock supervisor: pulses the PLL reset, waits for a stable lock,
// retries on timeout and is the single source of the downstream system reset.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked_stable,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             lk_meta_r, lk_sync_r;
  logic [3:0]       retry_r, retry_s;
  logic [7:0]       loss_r, loss_s;
  logic             pll_rst_r, sys_rst_r, locked_stable_r, fail_r;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_meta_r <= 1'b0;
      lk_sync_r <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_sync_r <= lk_meta_r;
    end
  end

  // Next-state, retry and lock-loss bookkeeping
  always_comb begin
    state_s = state_r;
    retry_s = retry_r;
    loss_s  = loss_r;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == RST_LAST) begin
          state_s = ST_WAIT_LOCK;
        end else begin
          state_s = ST_RESET_PLL;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen in the timeout cycle still wins
        if (lk_sync_r) begin
          state_s = ST_STABILIZE;
        end else if (cnt_r == TO_LAST) begin
          if (retry_r == RETRY_MAX) begin
            state_s = ST_FAIL;
          end else begin
            retry_s = retry_r + 4'd1;
            state_s = ST_RESET_PLL;
          end
        end else begin
          state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABILIZE: begin
        if (!lk_sync_r) begin
          state_s = ST_WAIT_LOCK;
        end else if (cnt_r == STAB_LAST) begin
          retry_s = 4'd0;
          state_s = ST_RUN;
        end else begin
          state_s = ST_STABILIZE;
        end
      end
      ST_RUN: begin
        retry_s = 4'd0;
        if (!lk_sync_r) begin
          if (loss_r != 8'hFF) begin
            loss_s = loss_r + 8'd1;
          end else begin
            loss_s = loss_r;
          end
          state_s = ST_RESET_PLL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FAIL: begin
        state_s = ST_FAIL;
      end
      default: begin
        state_s = ST_RESET_PLL;
      end
    endcase

    if (state_s != state_r) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // State, counter and registered outputs; outputs follow the next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r         <= ST_RESET_PLL;
      cnt_r           <= '0;
      retry_r         <= 4'd0;
      loss_r          <= 8'd0;
      pll_rst_r       <= 1'b1;
      sys_rst_r       <= 1'b1;
      locked_stable_r <= 1'b0;
      fail_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      retry_r         <= retry_s;
      loss_r          <= loss_s;
      pll_rst_r       <= (state_s == ST_RESET_PLL) || (state_s == ST_FAIL);
      sys_rst_r       <= (state_s != ST_RUN);
      locked_stable_r <= (state_s == ST_RUN);
      fail_r          <= (state_s == ST_FAIL);
    end
  end

  assign pll_rst         = pll_rst_r;
  assign sys_rst         = sys_rst_r;
  assign locked_stable   = locked_stable_r;
  assign fail            = fail_r;
  assign retry_count     = retry_r;
  assign lock_loss_count = loss_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues cycle-tagged expected
// output vectors, a negedge monitor pops and compares them.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       locked_stable;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .locked_stable  (locked_stable),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  // Expected vector layout: {pll_rst, sys_rst, locked_stable, fail, retry[3:0], loss[7:0]}
  typedef struct {
    int          cyc;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   done    = 1'b0;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk) cyc <= cyc + 1;

  function void expect_at(input int c, input string nm, input logic [15:0] v);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].cyc > c) idx--;
    sb_q.insert(idx, e);
  endfunction

  // Monitor: compare every expectation due at the edge just passed
  initial begin
    exp_t        e;
    logic [15:0] obs;
    forever begin
      @(negedge refclk);
      obs = {pll_rst, sys_rst, locked_stable, fail, retry_count, lock_loss_count};
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_total++;
        if (e.cyc < cyc) begin
          $display("FAIL %s: expectation for cycle %0d missed (now cycle %0d), required %h",
                   e.name, e.cyc, cyc, e.val);
        end else if (obs !== e.val) begin
          $display("FAIL %s @cycle %0d: got %h required %h", e.name, cyc, obs, e.val);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    tick();
    r = cyc;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
    end
  end

  int          r, n, l, r2;
  logic [7:0]  sat;

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Clean lock 20 cycles after the pulse ends
    do_reset(r);
    expect_at(r,     "reset_values",   16'hC000);
    expect_at(r + 3, "pulse_last_hi",  16'hC000);
    expect_at(r + 4, "pulse_fall",     16'h4000);
    n = r + 24;
    wait_until(n);
    pll_locked = 1'b1;
    expect_at(n + 3,  "clean_stabilize",  16'h4000);
    expect_at(n + 10, "clean_pre_release", 16'h4000);
    expect_at(n + 11, "clean_release",    16'h2000);
    wait_until(n + 12);

    // Glitchy lock: 5 high, 3 low, then steady
    pll_locked = 1'b0;
    do_reset(r);
    expect_at(r, "reset_from_run", 16'hC000);
    n = r + 10;
    wait_until(n);
    pll_locked = 1'b1;
    expect_at(n + 8,  "glitch_back_wait",  16'h4000);
    expect_at(n + 11, "glitch_no_release", 16'h4000);
    expect_at(n + 18, "glitch_pre_release", 16'h4000);
    expect_at(n + 19, "glitch_release",    16'h2000);
    wait_until(n + 5);
    pll_locked = 1'b0;
    wait_until(n + 8);
    pll_locked = 1'b1;
    wait_until(n + 20);

    // Recovery after the second pulse
    pll_locked = 1'b0;
    do_reset(r);
    expect_at(r,       "recov_reset",      16'hC000);
    expect_at(r + 103, "recov_last_wait",  16'h4000);
    expect_at(r + 104, "recov_pulse2",     16'hC100);
    expect_at(r + 107, "recov_pulse2_end", 16'hC100);
    expect_at(r + 108, "recov_wait2",      16'h4100);
    n = r + 120;
    wait_until(n);
    pll_locked = 1'b1;
    expect_at(n + 3,  "recov_stab_retry1", 16'h4100);
    expect_at(n + 10, "recov_pre_release", 16'h4100);
    expect_at(n + 11, "recov_run_clear",   16'h2000);
    wait_until(n + 12);

    // Lock loss in RUN, 300 times, loss count saturates at 255
    l = n + 12;
    for (int i = 1; i <= 300; i++) begin
      wait_until(l);
      pll_locked = 1'b0;
      sat = (i > 255) ? 8'd255 : 8'(i);
      expect_at(l + 3, "loss_count", {8'hC0, sat});
      tick();
      pll_locked = 1'b1;
      if (i == 1) begin
        expect_at(l + 6,  "loss_pulse_hi",  16'hC001);
        expect_at(l + 7,  "loss_pulse_end", 16'h4001);
        expect_at(l + 16, "loss_rerun",     16'h2001);
      end
      l = l + 17;
    end
    expect_at(l - 1, "loss_saturated_run", 16'h20FF);

    // Reset mid-STABILIZE
    wait_until(l);
    pll_locked = 1'b0;
    expect_at(l + 3,  "loss_stays_255", 16'hC0FF);
    expect_at(l + 10, "mid_stabilize",  16'h40FF);
    tick();
    pll_locked = 1'b1;
    wait_until(l + 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_at(l + 11, "stab_reset_values", 16'hC000);
    expect_at(l + 14, "stab_rst_pulse_hi", 16'hC000);
    expect_at(l + 15, "stab_rst_pulse_lo", 16'h4000);
    expect_at(l + 23, "stab_rst_pre_run",  16'h4000);
    expect_at(l + 24, "stab_rst_run",      16'h2000);
    wait_until(l + 25);

    // Retries exhausted, then reset out of FAIL
    pll_locked = 1'b0;
    do_reset(r);
    expect_at(r,       "fail_seq_reset",  16'hC000);
    expect_at(r + 3,   "fail_p1_hi",      16'hC000);
    expect_at(r + 4,   "fail_p1_lo",      16'h4000);
    expect_at(r + 103, "fail_w1_end",     16'h4000);
    expect_at(r + 104, "fail_p2_retry1",  16'hC100);
    expect_at(r + 108, "fail_w2",         16'h4100);
    expect_at(r + 207, "fail_w2_end",     16'h4100);
    expect_at(r + 208, "fail_p3_retry2",  16'hC200);
    expect_at(r + 212, "fail_w3",         16'h4200);
    expect_at(r + 311, "fail_w3_end",     16'h4200);
    expect_at(r + 312, "fail_enter",      16'hD200);
    expect_at(r + 400, "fail_sticky",     16'hD200);
    wait_until(r + 350);
    pll_locked = 1'b1;
    wait_until(r + 400);
    rst = 1'b1;
    tick();
    r2 = cyc;
    rst = 1'b0;
    expect_at(r2,      "fail_reset_values", 16'hC000);
    expect_at(r2 + 3,  "fail_rst_pulse_hi", 16'hC000);
    expect_at(r2 + 4,  "fail_rst_pulse_lo", 16'h4000);
    expect_at(r2 + 12, "fail_rst_pre_run",  16'h4000);
    expect_at(r2 + 13, "fail_rst_run",      16'h2000);
    wait_until(r2 + 15);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) tick();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_total++;
      $display("FAIL %s: never compared, required %h at cycle %0d", e.name, e.val, e.cyc);
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset-and-lock controller for the fractional core PLL. Runs on the free-running 74.25 MHz reference clock and drives the PLL reset. It watches the asynchronous `locked` output and retries the PLL on lock timeout. It releases the system reset only after lock has been stable for a programmable interval, and it is the single source of `sys_rst` for every PLL-derived domain.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: length of each `pll_rst` pulse, in refclk cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, 74250: maximum wait for lock after a pulse ends (1 ms at 74.25 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 3: timeouts tolerated before entering FAIL (1..15).

Ports:
- `refclk` in 1: sole clock (PLL reference, free-running).
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to refclk.
- `pll_rst` out 1: drives the PLL `rst` input.
- `sys_rst` out 1: active-high reset for downstream logic.
- `locked_stable` out 1: high only in RUN.
- `fail` out 1: retries exhausted; sticky until `rst`.
- `retry_count` out 4: timeouts since the last `rst` or the last entry to RUN.
- `lock_loss_count` out 8: number of lock losses in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-FF synchronizer, giving `lk_s`. Only `lk_s` is used internally.
- One shared cycle counter `cnt` (width sized to the largest parameter) is cleared on every state transition.
- All outputs are registered.
- States and transitions:
  - RESET_PLL: `pll_rst`=1. When `cnt`==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - If `lk_s`=1, go to STABILIZE.
    - Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1 (timeout):
      - if `retry_count`==MAX_RETRIES, go to FAIL;
      - else increment `retry_count` and go to RESET_PLL.
  - STABILIZE: `pll_rst`=0.
    - If `lk_s`=0, go to WAIT_LOCK. The timeout restarts from 0; this is not a retry.
    - Otherwise, when `cnt`==LOCK_STABLE_CYCLES-1, go to RUN.
  - RUN: `sys_rst`=0, `locked_stable`=1, `retry_count` cleared to 0.
    - If `lk_s`=0, increment `lock_loss_count` (saturating) and go to RESET_PLL.
  - FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Held until `rst`.
- `sys_rst`=1 in every state except RUN.
- Timeout and lock in the same cycle: lock wins (go to STABILIZE).
- `rst` has priority over every state and counter.

## Timing
- Reset values, while `rst`=1 and the cycle after it is sampled: state RESET_PLL, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `locked_stable`=0, `fail`=0, `retry_count`=0, `lock_loss_count`=0. Synchronizer flops are cleared to 0.
- After `rst` falls, `pll_rst` stays high for exactly RST_PULSE_CYCLES cycles.
- `pll_locked` rising at edge N is seen as `lk_s`=1 at edge N+2. The state is STABILIZE from edge N+3.
- `sys_rst` falls exactly LOCK_STABLE_CYCLES cycles after STABILIZE is entered, provided `lk_s` stays high throughout.
- Loss of lock: `pll_locked` falling at edge N gives `sys_rst`=1, `locked_stable`=0 and `pll_rst`=1 at edge N+3.
- Worst-case time to FAIL from `rst` release: (MAX_RETRIES+1)·(RST_PULSE_CYCLES+LOCK_TIMEOUT_CYCLES) cycles.
- `rst` asserted mid-operation, in any state, restores all reset values on the next edge. There is no partial completion.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: `pll_locked` rises 20 cycles after `pll_rst` falls and stays high → `pll_rst` high for exactly 4 cycles; `sys_rst` falls 2+1+8 cycles after the lock edge; `retry_count`=0, `fail`=0.
- Glitchy lock: `pll_locked` high for 5 cycles, low for 3, then steady → no `sys_rst` release during the glitch; the stable count restarts; release occurs 8 cycles after the second STABILIZE entry.
- Retries exhausted: `pll_locked` held at 0 → three `pll_rst` pulses with `retry_count` stepping 0→1→2, then FAIL after the 3rd timeout at cycle 3·104; `fail`=1, `pll_rst`=1, `sys_rst`=1 until `rst`.
- Recovery on retry: lock arrives only after the 2nd pulse → `retry_count`=1 during STABILIZE, cleared to 0 on entry to RUN; `fail` stays 0.
- Lock loss in RUN: drop `pll_locked` for 1 cycle → `sys_rst`=1 three cycles later, `lock_loss_count`=1, a new 4-cycle `pll_rst` pulse; repeat 300 times → count saturates at 255.
- Reset mid-STABILIZE and in FAIL: assert `rst` for 1 cycle → all outputs return to reset values the next cycle and the sequence restarts with a 4-cycle `pll_rst` pulse.
